// File: rtl/svm_pwm.sv
// Min-max space-vector modulator driving a center-aligned three-phase PWM.
// A three-stage command pipeline fills a shadow compare bank; the bank is loaded at each carrier period boundary.
module svm_pwm #(
    parameter int unsigned D_WIDTH = 16,
    parameter int unsigned Q_BITS  = 15,
    parameter int unsigned PERIOD  = 1024
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic signed [D_WIDTH-1:0] va_in,
    input  logic signed [D_WIDTH-1:0] vb_in,
    input  logic signed [D_WIDTH-1:0] vc_in,
    input  logic                      valid,
    output logic                      ready,
    output logic                      pwmA_out,
    output logic                      pwmB_out,
    output logic                      pwmC_out,
    output logic                      sync_out
);
    localparam int unsigned CW  = $clog2(PERIOD);
    localparam int unsigned DW1 = D_WIDTH + 1;
    localparam int unsigned DW2 = D_WIDTH + 2;
    localparam int unsigned PW  = Q_BITS + CW + 2;
    localparam logic signed [DW2-1:0] SatHi = DW2'((1 << Q_BITS) - 1);
    localparam logic signed [DW2-1:0] SatLo = DW2'(-(1 << Q_BITS));
    localparam logic signed [DW2-1:0] Bias  = DW2'(1 << Q_BITS);

    typedef enum logic {DirUp, DirDown} dir_e;

    logic signed [D_WIDTH-1:0] r_v0 [3];
    logic signed [D_WIDTH-1:0] r_v1 [3];
    logic signed [D_WIDTH-1:0] r_vmax, r_vmin, w_vmax, w_vmin;
    logic signed [DW2-1:0]     r_vs [3];
    logic signed [DW2-1:0]     w_vs [3];
    logic signed [DW2-1:0]     w_vx [3];
    logic signed [DW2-1:0]     w_biased [3];
    logic [PW-1:0]             w_prod [3];
    logic [CW-1:0]             w_cmp_new [3];
    logic [CW-1:0]             w_cmp_d [3];
    logic [CW-1:0]             r_shadow [3];
    logic [CW-1:0]             r_cmp [3];
    logic signed [DW1-1:0]     w_sum, w_voff;
    logic [2:0]                w_unused_bits;
    logic                      r_p0, r_p1, r_p2, r_shadow_full;
    logic [2:0]                r_pwm;
    logic                      r_sync;
    logic [CW-1:0]             r_cnt, w_cnt_d;
    dir_e                      r_dir, w_dir_d;
    logic                      w_accept, w_boundary, w_load;

    assign ready      = !(r_p0 || r_p1 || r_p2) && !r_shadow_full;
    assign w_accept   = valid && ready;
    assign w_boundary = (r_dir == DirDown) && (r_cnt == '0);
    assign w_load     = w_boundary && r_shadow_full;

    always_comb begin
        w_vmax = r_v0[0];
        w_vmin = r_v0[0];
        for (int i = 1; i < 3; i++) begin
            if (r_v0[i] > w_vmax) w_vmax = r_v0[i];
            if (r_v0[i] < w_vmin) w_vmin = r_v0[i];
        end
    end

    // Zero-sequence offset, saturation and scaling onto the carrier range.
    always_comb begin
        w_sum  = $signed({r_vmax[D_WIDTH-1], r_vmax}) + $signed({r_vmin[D_WIDTH-1], r_vmin});
        w_voff = -(w_sum >>> 1);
        for (int i = 0; i < 3; i++) begin
            w_vx[i] = $signed({{2{r_v1[i][D_WIDTH-1]}}, r_v1[i]})
                    + $signed({w_voff[DW1-1], w_voff});
            if (w_vx[i] > SatHi)      w_vs[i] = SatHi;
            else if (w_vx[i] < SatLo) w_vs[i] = SatLo;
            else                      w_vs[i] = w_vx[i];
            w_biased[i]      = r_vs[i] + Bias;
            w_prod[i]        = PW'(w_biased[i][Q_BITS:0]) * PW'(PERIOD);
            w_cmp_new[i]     = w_prod[i][Q_BITS+1 +: CW];
            w_unused_bits[i] = ^{w_biased[i][DW2-1:Q_BITS+1], w_prod[i][Q_BITS:0],
                                 w_prod[i][PW-1]};
            w_cmp_d[i]       = w_load ? r_shadow[i] : r_cmp[i];
        end
    end

    always_comb begin
        w_dir_d = r_dir;
        w_cnt_d = r_cnt;
        unique case (r_dir)
            DirUp: begin
                if (r_cnt == CW'(PERIOD - 1)) w_dir_d = DirDown;
                else                          w_cnt_d = r_cnt + CW'(1);
            end
            DirDown: begin
                if (r_cnt == '0) w_dir_d = DirUp;
                else             w_cnt_d = r_cnt - CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_dir <= DirUp;
            r_cnt <= '0;
        end else begin
            r_dir <= w_dir_d;
            r_cnt <= w_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_p0          <= 1'b0;
            r_p1          <= 1'b0;
            r_p2          <= 1'b0;
            r_shadow_full <= 1'b0;
            r_vmax        <= '0;
            r_vmin        <= '0;
            r_pwm         <= '0;
            r_sync        <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_v0[i]     <= '0;
                r_v1[i]     <= '0;
                r_vs[i]     <= '0;
                r_shadow[i] <= '0;
                r_cmp[i]    <= '0;
            end
        end else begin
            r_p0   <= w_accept;
            r_p1   <= r_p0;
            r_p2   <= r_p1;
            r_vmax <= w_vmax;
            r_vmin <= w_vmin;
            if (w_accept) begin
                r_v0[0] <= va_in;
                r_v0[1] <= vb_in;
                r_v0[2] <= vc_in;
            end
            // A stage-3 write coinciding with a boundary only arms the shadow.
            if (r_p2)        r_shadow_full <= 1'b1;
            else if (w_load) r_shadow_full <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_v1[i] <= r_v0[i];
                r_vs[i] <= w_vs[i];
                if (r_p2) r_shadow[i] <= w_cmp_new[i];
                r_cmp[i] <= w_cmp_d[i];
                // Compared against next-state values so the output lines up with r_cnt.
                r_pwm[i] <= (w_cnt_d < w_cmp_d[i]);
            end
            r_sync <= w_boundary;
        end
    end

    assign pwmA_out = r_pwm[0];
    assign pwmB_out = r_pwm[1];
    assign pwmC_out = r_pwm[2];
    assign sync_out = r_sync;

endmodule

// File: tb/tb_svm_pwm.sv
// Scoreboard bench for svm_pwm at PERIOD=16: commands push expected compare triples and a
// monitor checks each full carrier period's PWM pattern against the active expectation.
module tb_svm_pwm;
    localparam int P = 16;

    typedef struct {
        int a;
        int b;
        int c;
    } exp_t;

    logic               clk = 1'b0;
    logic               rstb = 1'b0;
    logic signed [15:0] va = '0, vb = '0, vc = '0;
    logic               valid = 1'b0;
    logic               ready, pwm_a, pwm_b, pwm_c, sync;
    logic [2:0]         pwm_v;
    int                 n_checks = 0;
    int                 n_fail = 0;
    exp_t               sb_q[$];

    svm_pwm #(.D_WIDTH(16), .Q_BITS(15), .PERIOD(P)) dut (
        .clk      (clk),
        .rstb     (rstb),
        .va_in    (va),
        .vb_in    (vb),
        .vc_in    (vc),
        .valid    (valid),
        .ready    (ready),
        .pwmA_out (pwm_a),
        .pwmB_out (pwm_b),
        .pwmC_out (pwm_c),
        .sync_out (sync)
    );

    assign pwm_v = {pwm_c, pwm_b, pwm_a};

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_phase(input string nm, input logic [2*P-1:0] win, input int cmp);
        int up_e, dn_e;
        up_e = (1 << cmp) - 1;
        dn_e = ((1 << P) - 1) & ~((1 << (P - cmp)) - 1);
        check({nm, "_up_half"}, int'(win[P-1:0]), up_e);
        check({nm, "_dn_half"}, int'(win[2*P-1:P]), dn_e);
    endtask

    // Monitor: each window spans sync to sync; a ready rise at sync marks a compare load.
    initial begin
        int               mon_idx;
        bit               mon_active;
        bit               prev_ready;
        exp_t             cur;
        logic [2*P-1:0]   win [3];
        mon_idx    = 0;
        mon_active = 1'b0;
        prev_ready = 1'b1;
        cur.a = 0; cur.b = 0; cur.c = 0;
        forever begin
            @(negedge clk);
            if (!rstb) begin
                mon_active = 1'b0;
                prev_ready = 1'b1;
                cur.a = 0; cur.b = 0; cur.c = 0;
                sb_q.delete();
            end else begin
                if (ready && !prev_ready) check("ready_rise_at_sync", int'(sync), 1);
                if (sync) begin
                    if (mon_active) begin
                        check("period_len", mon_idx, 2 * P);
                        check_phase("pwmA", win[0], cur.a);
                        check_phase("pwmB", win[1], cur.b);
                        check_phase("pwmC", win[2], cur.c);
                    end
                    if (ready && !prev_ready) begin
                        check("load_has_expectation", int'(sb_q.size() > 0), 1);
                        if (sb_q.size() > 0) cur = sb_q.pop_front();
                    end
                    mon_active = 1'b1;
                    mon_idx    = 0;
                    for (int k = 0; k < 3; k++) win[k] = '0;
                end
                if (mon_active && mon_idx < 2 * P) begin
                    for (int k = 0; k < 3; k++) win[k][mon_idx] = pwm_v[k];
                end
                if (mon_active) mon_idx++;
                prev_ready = ready;
            end
        end
    end

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_ready_wait"}, int'(ready), 1);
    endtask

    task automatic wait_sync(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sync && n < 100);
        check({nm, "_sync_wait"}, int'(sync), 1);
    endtask

    task automatic send(input string nm, input int a, input int b, input int c,
                        input int ea, input int eb, input int ec);
        exp_t e;
        wait_ready(nm);
        va    = a[15:0];
        vb    = b[15:0];
        vc    = c[15:0];
        valid = 1'b1;
        e.a = ea; e.b = eb; e.c = ec;
        sb_q.push_back(e);
        @(negedge clk);
        valid = 1'b0;
        check({nm, "_ready_low"}, int'(ready), 0);
    endtask

    task automatic count_first_sync(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sync && n < 100);
        check(nm, n, 2 * P);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", int'(ready), 1);
        check("rst_pwm", int'(pwm_v), 0);
        check("rst_sync", int'(sync), 0);
        rstb = 1'b1;
        count_first_sync("first_sync");

        send("zero", 0, 0, 0, 8, 8, 8);
        send("t2", 16384, -8192, -8192, 11, 5, 5);

        // Let t2 run one full period, then reset mid-period with a command in flight.
        wait_ready("t2_load");
        wait_sync("t2_period");
        @(negedge clk);
        va = 16'sd1000; vb = 16'sd2000; vc = -16'sd3000;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        check("pre_rst_pwm", int'(pwm_v), 7);
        #2 rstb = 1'b0;
        #1;
        check("mid_rst_pwm", int'(pwm_v), 0);
        check("mid_rst_ready", int'(ready), 1);
        check("mid_rst_sync", int'(sync), 0);
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        count_first_sync("first_sync_after_rst");

        send("sat", 32767, -32768, 0, 15, 0, 8);

        send("t4", -16384, 16384, 0, 4, 12, 8);
        va = -16'sd16384; vb = -16'sd16384; vc = -16'sd16384;
        valid = 1'b1;
        repeat (5) @(negedge clk);
        valid = 1'b0;

        // Align the stage-3 write with a boundary edge; the load must slip one period.
        wait_ready("t4_load");
        repeat (28) @(negedge clk);
        send("defer", 8192, 0, -8192, 10, 8, 6);
        repeat (3) @(negedge clk);
        check("defer_sync", int'(sync), 1);
        check("defer_ready_low", int'(ready), 0);

        send("b2b0", 4096, 0, -4096, 9, 8, 7);
        send("b2b1", 20000, -10000, -10000, 11, 4, 4);
        send("b2b2", -20000, 10000, 5000, 4, 11, 10);
        send("b2b3", 0, -8191, -8191, 9, 7, 7);
        wait_ready("b2b3_load");
        wait_sync("final_period");
        check("queue_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/svm_pwm.md
# svm_pwm

Min-max space-vector modulator and center-aligned three-phase PWM generator. It is the last stage of the FOC datapath. It accepts the three phase voltage commands produced by inverse_clarke and applies zero-sequence (min-max) injection. It converts the result to compare values, double-buffers them, and drives pwmA/B/C against a shared triangle carrier. Its `ready` output is the SVM-done indication polled by the FOC sequencer.

## Interface
- D_WIDTH, 16, width of signed phase-voltage inputs
- Q_BITS, 15, fractional bits of inputs; full scale ±2^Q_BITS
- PERIOD, 1024, carrier half-period in clk cycles; carrier period = 2*PERIOD; power of two, ≥4
- clk  in  1  clock
- rstb  in  1  reset, asynchronous, active-low
- va_in, vb_in, vc_in  in  D_WIDTH each  signed phase voltage commands, Q(D_WIDTH-Q_BITS).Q_BITS
- valid  in  1  input strobe; accepted when valid && ready
- ready  out  1  high when block can accept a new command (pipeline idle, shadow empty)
- pwmA_out, pwmB_out, pwmC_out  out  1  PWM outputs, high = upper switch on
- sync_out  out  1  one-cycle pulse in first cycle of every carrier period

## Operation
- Accept (cycle A): latch va/vb/vc into stage-0 regs; ready falls next cycle.
- Stage 1 (A+1): vmax = max(va,vb,vc), vmin = min(va,vb,vc), signed compare.
- Stage 2 (A+2): voff = -((vmax+vmin) >>> 1), arithmetic shift (floor), computed in D_WIDTH+1 bits. vX' = vX + voff in D_WIDTH+2 bits, saturated to [-2^Q_BITS, 2^Q_BITS-1].
- Stage 3 (A+3): cmpX = ((vX' + 2^Q_BITS) * PERIOD) >> (Q_BITS+1), unsigned, range 0..PERIOD-1. Write to shadow regs and set shadow_full.
- Carrier: cnt counts up 0..PERIOD-1, holds PERIOD-1 one extra cycle, counts down to 0, holds 0 one extra cycle. dir flips at each endpoint's second cycle, giving period 2*PERIOD.
- Period boundary: the edge leaving the second cycle at cnt==0 (dir down→up). At that edge, if shadow_full (registered value), active cmp ← shadow and shadow_full ← 0.
- pwmX_out = (cnt < active cmpX), registered. High time per period = exactly 2*cmpX cycles, centered on cnt==0.
- ready = !pipeline_busy && !shadow_full. Commands arriving while ready=0 are ignored, not queued.
- Simultaneous stage-3 write and boundary with shadow_full=0: no load occurs. shadow_full ← 1, and the value loads at the next boundary.

## Timing
- Reset (async): cnt=0, dir=up, active/shadow cmp=0, shadow_full=0, pipeline empty. Outputs: pwmA/B/C_out=0, sync_out=0, ready=1.
- Reset mid-operation clears everything immediately. Any pending or in-flight command is discarded.
- Accept→shadow: 3 cycles. Shadow→outputs: at the next period boundary. PWM reflects the new cmp in the first cycle of the new period (one register stage).
- ready returns high the cycle after the boundary load. Worst case is 3 + 2*PERIOD cycles after accept.
- sync_out is high in the first cycle with dir=up, cnt=0, i.e. the cycle after each boundary edge. The first pulse comes 2*PERIOD cycles after reset release.
- Carrier runs free, independent of valid/ready.

## Test plan
- Reset, hold, release (PERIOD=16) -> all pwm=0, ready=1. sync_out pulses every 32 cycles. Assert rstb mid-period -> outputs 0 same cycle.
- va=vb=vc=0, valid one cycle -> ready low from accept+1. After next boundary, cmp=8 on all phases. Each pwm is high 16 of 32 cycles, centered on cnt=0. ready returns high after load.
- va=16384, vb=-8192, vc=-8192 -> voff=-4096, v'=12288/-12288/-12288. cmpA=11, cmpB=cmpC=5; high times 22/10/10 cycles.
- va=32767, vb=-32768, vc=0 -> voff=+1. A saturates to 32767, giving cmp 15/0/8; pwmB stays 0 for the whole period.
- Second valid while ready=0 -> ignored, active cmp unchanged. Time stage-3 write to coincide with a boundary edge -> load deferred exactly one period.
- Back-to-back commands, each issued on the ready rising edge over 4 periods -> each command is applied in successive periods with no skipped or duplicated period.
